// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer for the E stage of the MIPS pipeline.
// Owns the architectural HI/LO registers. mult/multu/div/divu compute their
// 64-bit result at issue, hold it in pend_hi/pend_lo, and commit it to HI/LO
// after a fixed busy period. mthi/mtlo write HI/LO directly; mfhi/mflo read
// them on md_out.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   md_en      E-stage instruction valid, not flushed, not stalled
//   md_op      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//              7 mfhi, 8 mflo, 9-15 none
//   rs_data    rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_data    rt operand (divisor / multiplier)
//   d_md_use   D-stage instruction is an MDU op
//   start      mult/div accepted this cycle
//   busy       operation in flight
//   stall_req  hold the D-stage MDU instruction
//   md_out     HI for mfhi, LO for mflo, else 0
//   hi, lo     architectural HI/LO registers
//
// state | meaning
// IDLE  | no operation in flight; accepts mult/div and mthi/mtlo
// RUN   | counting down the busy period; commits pend_* when cnt reaches 1
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;
  logic          commit;
  logic          is_mul, is_div;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;
  logic [63:0]   prod_s, prod_u;

  assign is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign busy      = (state == RUN);
  assign start     = md_en && (is_mul || is_div) && !busy;
  assign stall_req = d_md_use && (start || busy);

  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI) md_out = hi;
    else if (md_op == OP_MFLO) md_out = lo;
  end

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // res_wr=0 marks a divide by zero: the busy period runs but HI/LO keep their value.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (rt_data == 32'd0) begin
          res_wr = 1'b0;
        end else if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $unsigned($signed(rs_data) / $signed(rt_data));
          res_hi = $unsigned($signed(rs_data) % $signed(rt_data));
        end
      end
      OP_DIVU: begin
        if (rt_data == 32'd0) begin
          res_wr = 1'b0;
        end else begin
          res_lo = rs_data / rt_data;
          res_hi = rs_data % rt_data;
        end
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end
      // commit only happens while busy, so it never collides with mthi/mtlo
      if (commit && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (md_en && !busy && md_op == OP_MTHI) hi <= rs_data;
      if (md_en && !busy && md_op == OP_MTLO) lo <= rs_data;
    end
  end

  // The pipeline should stall such requests; the unit drops them.
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(md_en && (is_mul || is_div) && busy))
    else $warning("md_unit: mult/div request while busy was ignored");

endmodule
